// File: rtl/fpga_config_loader.sv
// Streams bitstream words into fabric columns one per handshake, then releases the fabric
// flip-flops after a settle interval and reports ready once the arm gap has elapsed.
module fpga_config_loader #(
  parameter int unsigned WORD_W        = 320,
  parameter int unsigned NUM_COLS      = 172,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned ARM_GAP       = 4
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [WORD_W-1:0]   configs_in,
  output logic [NUM_COLS-1:0] configs_en,
  output logic                ff_en,
  output logic                rdy,
  output logic                busy
);

  localparam int unsigned ColW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned DlyMax = (SETTLE_CYCLES > ARM_GAP) ? SETTLE_CYCLES : ARM_GAP;
  localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;

  localparam logic [ColW-1:0] ColLast    = ColW'(NUM_COLS - 1);
  localparam logic [DlyW-1:0] SettleLast = DlyW'(SETTLE_CYCLES - 1);
  localparam logic [DlyW-1:0] ArmLast    = DlyW'(ARM_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StSettle,
    StArm,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [NUM_COLS-1:0] en_q, en_d;
  logic                ff_en_q, ff_en_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dly_d   = dly_q;
    word_d  = word_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          col_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_valid && cfg_ready_q) begin
          word_d  = cfg_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (col_q == ColLast) begin
          state_d = StSettle;
          dly_d   = '0;
        end else begin
          col_d   = col_q + ColW'(1);
          state_d = StLoad;
        end
      end
      StSettle: begin
        if (dly_q == SettleLast) begin
          state_d = StArm;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StArm: begin
        if (dly_q == ArmLast) begin
          state_d = StDone;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StDone: begin
        if (start) begin
          state_d = StLoad;
          col_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    cfg_ready_d = (state_d == StLoad);
    en_d        = (state_d == StWrite) ? (NUM_COLS'(1) << col_d) : '0;
    ff_en_d     = (state_d == StArm) || (state_d == StDone);
    rdy_d       = (state_d == StDone);
    busy_d      = (state_d != StIdle) && (state_d != StDone);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      dly_q       <= '0;
      word_q      <= '0;
      cfg_ready_q <= 1'b0;
      en_q        <= '0;
      ff_en_q     <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dly_q       <= dly_d;
      word_q      <= word_d;
      cfg_ready_q <= cfg_ready_d;
      en_q        <= en_d;
      ff_en_q     <= ff_en_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign configs_in = word_q;
  assign configs_en = en_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Synthesizable configuration loader that sits directly upstream of the `fpga` fabric. It accepts bitstream words over a valid/ready stream and writes each word to one fabric column. It drives `configs_in` and a one-hot `configs_en` column strobe. After a settle interval it asserts `ff_en` to release the fabric flip-flops, then `rdy` to tell the system the user design is live. It replaces the behavioural file-reading loader used in simulation wrappers, so on-chip or host-fed configuration uses the same sequence.

## Interface
- `WORD_W`, 320: config word width; matches fabric `configs_in`.
- `NUM_COLS`, 172: number of column enables and number of words per bitstream.
- `SETTLE_CYCLES`, 10: idle cycles after the last column write, before `ff_en`.
- `ARM_GAP`, 4: cycles from `ff_en` rising to `rdy` rising.

- `clock`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request to begin (re)configuration.
- `cfg_data`  in  WORD_W  bitstream word; word 0 goes to column 0.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `configs_in`  out  WORD_W  registered word presented to the fabric.
- `configs_en`  out  NUM_COLS  one-hot column write strobe.
- `ff_en`  out  1  fabric flip-flop enable.
- `rdy`  out  1  configuration complete; fabric running.
- `busy`  out  1  high in every state except IDLE and DONE.

## Operation
- States: IDLE, LOAD, WRITE, SETTLE, ARM, DONE. A word counter `col` of width `$clog2(NUM_COLS)` and a shared delay counter support them.
- Reset (`rst`=0 at an edge) is applied from any state, including mid-load:
  - state returns to IDLE;
  - `configs_in`=0, `configs_en`=0, `ff_en`=0, `rdy`=0, `cfg_ready`=0, `busy`=0, `col`=0;
  - a partial load is abandoned and no further column strobes are issued.
- IDLE: `start`=1 moves to LOAD with `col`=0. All other inputs are ignored.
- LOAD: `cfg_ready`=1. On `cfg_valid`&&`cfg_ready`, `configs_in`<=`cfg_data` and the state moves to WRITE. Otherwise the block stalls indefinitely with outputs held.
- WRITE: lasts exactly one cycle.
  - `configs_en` = 1<<`col`; it is 0 in every other state.
  - `cfg_ready`=0.
  - `configs_in` is stable for the whole cycle.
  - If `col`==NUM_COLS-1, go to SETTLE; otherwise `col`++ and go to LOAD.
- SETTLE: lasts SETTLE_CYCLES cycles with `configs_en`=0, then goes to ARM.
- ARM: `ff_en`=1 for ARM_GAP cycles, then goes to DONE.
- DONE: `ff_en`=1, `rdy`=1, `configs_in` holds the last word.
  - `start`=1 restarts: `ff_en`, `rdy` and `col` clear on the next cycle and the state moves to LOAD.
- `start` is ignored in LOAD, WRITE, SETTLE and ARM.
- `cfg_valid` is ignored outside LOAD. Words beyond NUM_COLS are never accepted.
- At most one bit of `configs_en` is ever high. Each column is strobed exactly once per load, in ascending order.

## Timing
- All outputs are registered. No combinational path exists from any input to any output, including `cfg_ready`.
- Cycle numbering:
  - `start` is sampled in cycle t, so LOAD begins in cycle t+1.
  - With `cfg_valid` held high, word k is accepted in cycle t+1+2k.
  - The strobe for word k is in cycle t+2+2k.
- Full-rate load takes 2·NUM_COLS cycles; `cfg_ready` toggles every cycle (50% throughput).
- With the defaults:
  - last strobe, `configs_en[171]`, in cycle t+344;
  - SETTLE in cycles t+345..t+354;
  - `ff_en` rises in cycle t+355;
  - `rdy` rises in cycle t+359.
- Stalls on `cfg_valid` shift all later events by the stall length and nothing else.
- Reset asserted in the same cycle as `start` or a handshake: reset wins.

## Test plan
- Reset check: hold `rst`=0 for 3 cycles with `start`=1 and `cfg_valid`=1 → all outputs 0, state IDLE, no strobe.
- Full-rate load with defaults: word k = {WORD_W{k[0]}} ^ k, `cfg_valid` always 1 →
  - 172 strobes, one-hot and ascending;
  - at each strobe, `configs_in` equals word k;
  - `ff_en` rises at t+355 and `rdy` at t+359.
- Backpressure, NUM_COLS=4: `cfg_valid` random at 30% duty →
  - exactly 4 strobes in order 1,2,4,8, with correct data;
  - `ff_en` rises exactly SETTLE_CYCLES+1 cycles after the strobe of 8.
- Reset mid-load, NUM_COLS=8: assert `rst` after the strobe for column 3 →
  - outputs clear on the next cycle;
  - a later `start` reloads from column 0;
  - no strobe reaches column 4 before that restart.
- Ignored start and reconfigure, NUM_COLS=4:
  - pulse `start` during SETTLE → no effect;
  - in DONE, pulse `start` → `ff_en`/`rdy` fall the next cycle and a second 4-word load completes with `rdy` high again.
- Excess data, NUM_COLS=4: present 6 valid words → only 4 accepted, and `cfg_ready`=0 from SETTLE onward.
